// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency mult/multu (5 cycles) and div/divu (10 cycles),
// plus single-edge mthi/mtlo writes. HI/LO only change at the completion edge or on an idle move.
module mul_div_unit #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    output logic                 busy,
    output logic                 stall_req,
    output logic [DataWidth-1:0] hi,
    output logic [DataWidth-1:0] lo
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam logic [DataWidth-1:0] One = {{(DataWidth-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [3:0]           count_q, count_d;
    logic [2:0]           op_q, op_d;
    logic [DataWidth-1:0] a_q, a_d, b_q, b_d;
    logic [DataWidth-1:0] hi_q, hi_d, lo_q, lo_d;

    logic                   isLongOp, accept;
    logic                   signedMul, signedDiv, negA, negB;
    logic [2*DataWidth-1:0] prod;
    logic [DataWidth-1:0]   magA, magB, divisor, quotMag, remMag, quot, rem;

    assign busy      = (state_q == RUN);
    assign isLongOp  = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    assign accept    = start && !busy && isLongOp;
    assign stall_req = busy || (start && isLongOp);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Signed division works on magnitudes so that MIN / -1 wraps cleanly instead of trapping.
    always_comb begin
        signedMul = (op_q == OpMult);
        signedDiv = (op_q == OpDiv);
        prod      = {{DataWidth{signedMul & a_q[DataWidth-1]}}, a_q}
                  * {{DataWidth{signedMul & b_q[DataWidth-1]}}, b_q};
        negA      = signedDiv & a_q[DataWidth-1];
        negB      = signedDiv & b_q[DataWidth-1];
        magA      = negA ? -a_q : a_q;
        magB      = negB ? -b_q : b_q;
        divisor   = (b_q == '0) ? One : magB;
        quotMag   = magA / divisor;
        remMag    = magA % divisor;
        quot      = (negA ^ negB) ? -quotMag : quotMag;
        rem       = negA ? -remMag : remMag;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    count_d = ((op == OpMult) || (op == OpMultu)) ? 4'd5 : 4'd10;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                end else if (start && (op == OpMthi)) begin
                    hi_d = a;
                end else if (start && (op == OpMtlo)) begin
                    lo_d = a;
                end
            end
            RUN: begin
                if (count_q == 4'd1) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    if ((op_q == OpMult) || (op_q == OpMultu)) begin
                        hi_d = prod[2*DataWidth-1:DataWidth];
                        lo_d = prod[DataWidth-1:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
